// File: rtl/ahb_lite_master.sv
// Single-outstanding AHB-Lite manager: one valid/ready request becomes one
// SINGLE/NONSEQ transfer and one response pulse.
// Ports: HCLK/HRESETn; client req_* in, rsp_* out; AHB h* manager signals.
// Optional build macro AHB_MASTER_TIMEOUT_EN adds a data-phase wait timeout.
module ahb_lite_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hsize,
  output logic [2:0]            hburst,
  output logic [3:0]            hprot,
  output logic                  hmastlock,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hready,
  input  logic                  hresp
);

  localparam int LB = $clog2(DATA_WIDTH / 8);
  localparam int SW = LB + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept;
  logic                  bad;
  logic                  tmo;
  logic [LB-1:0]         amask;
  logic [SW-1:0]         sh;
  logic [DATA_WIDTH-1:0] bmask;
  logic [DATA_WIDTH-1:0] rdata_x;

  assign req_ready = (state == S_IDLE) & ~rsp_valid;
  assign accept    = req_valid & req_ready;

  // Oversized or unaligned requests never reach the bus.
  assign amask = LB'((32'd1 << req_size) - 32'd1);
  assign bad   = (req_size > 3'(LB))
               | (|(req_addr[LB-1:0] & amask));

  assign sh      = {haddr[LB-1:0], 3'b000};
  assign bmask   = ~({DATA_WIDTH{1'b1}} << (32'd8 << hsize));
  assign rdata_x = (hrdata >> sh) & bmask;

  assign htrans    = (state == S_ADDR) ? 2'b10 : 2'b00;
  assign hburst    = 3'b000;
  assign hprot     = 4'b0011;
  assign hmastlock = 1'b0;

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;

  assign tmo = (state == S_DATA) & ~hready
             & (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tmo_cnt <= '0;
    end else if (state != S_DATA || hready) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign tmo        = 1'b0;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept && !bad) state_nx = S_ADDR;
      S_ADDR: if (hready) state_nx = S_DATA;
      S_DATA: if (hready || tmo) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      haddr     <= '0;
      hwrite    <= 1'b0;
      hsize     <= 3'b000;
      hwdata    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      if (state == S_IDLE && accept) begin
        if (bad) begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end else begin
          haddr   <= req_addr;
          hwrite  <= req_write;
          hsize   <= req_size;
          wdata_q <= req_wdata;
        end
      end
      if (state == S_ADDR && hready) begin
        hwdata <= hwrite ? (wdata_q << sh) : '0;
      end
      if (state == S_DATA && hready) begin
        rsp_valid <= 1'b1;
        rsp_err   <= hresp;
        rsp_rdata <= (hresp || hwrite) ? '0 : rdata_x;
      end
      if (tmo) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master.
// Expected responses are queued at request time and popped on rsp_valid.
module tb_ahb_lite_master;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  ahb_lite_master #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hprot     (hprot),
    .hmastlock (hmastlock),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic e, input logic [31:0] d);
    exp_t x;
    x.err   = e;
    x.rdata = d;
    sb.push_back(x);
  endtask

  task automatic do_req(input string tag,
                        input logic w,
                        input logic [31:0] a,
                        input logic [2:0] s,
                        input logic [31:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_size  = s;
    req_wdata = d;
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    exp_t x;
    int   n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, 32'(rsp_valid), 32'd1);
    if (rsp_valid === 1'b1) begin
      chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk({tag, "_err"}, 32'(rsp_err), 32'(x.err));
        chk({tag, "_rdata"}, rsp_rdata, x.rdata);
      end
    end
    tick();
    chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    HRESETn   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_wdata = '0;
    hrdata    = '0;
    hready    = 1'b1;
    hresp     = 1'b0;
    tick();
    tick();

    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_hsize", 32'(hsize), 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_hburst", 32'(hburst), 32'd0);
    chk("rst_hprot", 32'(hprot), 32'd3);
    chk("rst_hmastlock", 32'(hmastlock), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    HRESETn = 1'b1;
    tick();

    // word write, zero wait states
    do_req("wr4", 1'b1, 32'h4, 3'd2, 32'h0000_00A5);
    chk("wr4_htrans", 32'(htrans), 32'h2);
    chk("wr4_haddr", haddr, 32'h4);
    chk("wr4_hsize", 32'(hsize), 32'd2);
    chk("wr4_hwrite", 32'(hwrite), 32'd1);
    chk("wr4_busy", 32'(req_ready), 32'd0);
    tick();
    chk("wr4_dtrans", 32'(htrans), 32'h0);
    chk("wr4_hwdata", hwdata, 32'h0000_00A5);
    chk("wr4_early", 32'(rsp_valid), 32'd0);
    push(1'b0, 32'h0);
    tick();
    chk("wr4_lat", 32'(rsp_valid), 32'd1);
    wait_rsp("wr4");

    // byte read from lane 2
    hrdata = 32'h00AB_0000;
    do_req("rdb", 1'b0, 32'h6, 3'd0, 32'h0);
    chk("rdb_htrans", 32'(htrans), 32'h2);
    chk("rdb_hsize", 32'(hsize), 32'd0);
    chk("rdb_hwrite", 32'(hwrite), 32'd0);
    push(1'b0, 32'h0000_00AB);
    wait_rsp("rdb");

    // halfword write to upper lanes
    do_req("wrh", 1'b1, 32'h2, 3'd1, 32'h0000_1234);
    tick();
    chk("wrh_hwdata", hwdata, 32'h1234_0000);
    push(1'b0, 32'h0);
    wait_rsp("wrh");

    // misaligned word: no bus transfer
    do_req("mis", 1'b0, 32'h2, 3'd2, 32'h0);
    chk("mis_htrans", 32'(htrans), 32'h0);
    chk("mis_ready", 32'(req_ready), 32'd0);
    push(1'b1, 32'h0);
    wait_rsp("mis");

    // oversized request
    do_req("big", 1'b0, 32'h0, 3'd3, 32'h0);
    chk("big_htrans", 32'(htrans), 32'h0);
    push(1'b1, 32'h0);
    wait_rsp("big");

    // three wait states in address and data phase
    hready = 1'b0;
    do_req("wt", 1'b1, 32'h8, 3'd2, 32'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      chk("wt_a_htrans", 32'(htrans), 32'h2);
      chk("wt_a_haddr", haddr, 32'h8);
      tick();
    end
    hready = 1'b1;
    tick();
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wt_d_htrans", 32'(htrans), 32'h0);
      chk("wt_d_hwdata", hwdata, 32'hCAFE_F00D);
      chk("wt_d_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    hready = 1'b1;
    push(1'b0, 32'h0);
    wait_rsp("wt");

    // two-cycle ERROR response on a read
    hrdata = 32'h55AA_55AA;
    do_req("er", 1'b0, 32'hC, 3'd2, 32'h0);
    tick();
    hready = 1'b0;
    hresp  = 1'b1;
    chk("er_htrans1", 32'(htrans), 32'h0);
    tick();
    chk("er_htrans2", 32'(htrans), 32'h0);
    chk("er_rsp", 32'(rsp_valid), 32'd0);
    hready = 1'b1;
    push(1'b1, 32'h0);
    wait_rsp("er");
    hresp = 1'b0;

    // error on first data cycle, byte write to lane 3
    do_req("ef", 1'b1, 32'h3, 3'd0, 32'h0000_005A);
    tick();
    chk("ef_hwdata", hwdata, 32'h5A00_0000);
    hresp = 1'b1;
    push(1'b1, 32'h0);
    wait_rsp("ef");
    hresp = 1'b0;

`ifdef AHB_MASTER_TIMEOUT_EN
    do_req("to", 1'b0, 32'h10, 3'd2, 32'h0);
    tick();
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait", 32'(rsp_valid), 32'd0);
    end
    tick();
    chk("to_fire", 32'(rsp_valid), 32'd1);
    push(1'b1, 32'h0);
    wait_rsp("to");
    hready = 1'b1;
`endif

    // reset during data phase aborts silently
    do_req("ab", 1'b1, 32'h20, 3'd2, 32'h1111_2222);
    tick();
    hready = 1'b0;
    #2;
    HRESETn = 1'b0;
    #1;
    chk("ab_htrans", 32'(htrans), 32'h0);
    chk("ab_ready", 32'(req_ready), 32'd1);
    chk("ab_hwdata", hwdata, 32'h0);
    #2;
    HRESETn = 1'b1;
    hready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ab_norsp", 32'(rsp_valid), 32'd0);
    end

    // recovery: halfword read from upper lanes
    hrdata = 32'hBEEF_0000;
    do_req("rh", 1'b0, 32'h2, 3'd1, 32'h0);
    push(1'b0, 32'h0000_BEEF);
    wait_rsp("rh");

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
